// File: rtl/hc_pkg.sv
// Shared constants and helpers for the HC logic family models.
// Delays are counted in global simulation ticks.
package hc_pkg;

    localparam int HC27_DELAY  = 9;
    localparam int HC161_DELAY = 17;
    localparam int MAX_DELAY   = 32;

    typedef struct packed {
        logic       tc;
        logic [3:0] q;
    } cnt_out_t;

    function automatic logic tc_of(input logic cet, input logic [3:0] c);
        return cet & (c == 4'hF);
    endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-depth propagation delay; reset preloads every stage.
// Shared by library parts that model pin-to-pin delay.
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] init,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stg [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stg[i] <= init;
        end else begin
            stg[0] <= d;
            for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
        end
    end

    assign q = stg[DEPTH-1];

endmodule

// File: rtl/u74hc161.sv
// 74HC161 4-bit synchronous counter, cp sampled on the global tick.
// Outputs pass through a fixed tick delay before reaching the pins.
module u74hc161
    import hc_pkg::*;
#(
    parameter logic [3:0] ic    = 4'h0,
    parameter int         delay = HC161_DELAY
) (
    input  logic clk,
    input  logic rst,
    input  logic vcc,
    input  logic gnd,
    input  logic mr_n,
    input  logic cp,
    input  logic pe_n,
    input  logic cep,
    input  logic cet,
    input  logic p0,
    input  logic p1,
    input  logic p2,
    input  logic p3,
    output logic q0,
    output logic q1,
    output logic q2,
    output logic q3,
    output logic tc
);

    if (delay < 1 || delay > MAX_DELAY) begin : g_bad_delay
        $error("u74hc161: delay out of range 1..32");
    end

    logic       vrst;
    logic       cp_prev;
    logic       cp_rise;
    logic [3:0] count;
    cnt_out_t   cur;
    cnt_out_t   rst_val;
    cnt_out_t   dly;
    logic       unused_gnd;

    assign vrst       = rst | ~vcc;
    assign cp_rise    = cp & ~cp_prev;
    assign unused_gnd = gnd;

    // Clear is checked every tick, so it behaves as asynchronous on the board.
    always_ff @(posedge clk) begin
        if (vrst) begin
            count   <= ic;
            cp_prev <= 1'b1;
        end else begin
            cp_prev <= cp;
            if (!mr_n) begin
                count <= 4'h0;
            end else if (cp_rise) begin
                if (!pe_n) begin
                    count <= {p3, p2, p1, p0};
                end else if (cep & cet) begin
                    count <= count + 4'd1;
                end
            end
        end
    end

    assign cur     = {tc_of(cet, count), count};
    assign rst_val = {tc_of(cet, ic), ic};

    delay_line #(
        .WIDTH($bits(cnt_out_t)),
        .DEPTH(delay)
    ) u_dly (
        .clk  (clk),
        .rst  (vrst),
        .init (rst_val),
        .d    (cur),
        .q    (dly)
    );

    assign {q3, q2, q1, q0} = dly.q;
    assign tc               = dly.tc;

endmodule

// File: tb/tb_u74hc161.sv
// Directed and random checks of two u74hc161 instances (ic=5, ic=3)
// against a tick-history reference model.
module tb_u74hc161;

    localparam int D  = 17;
    localparam int NT = 4000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, vcc, gnd, mr_n, cp, pe_n, cep, cet;
    logic [3:0] p;
    logic [3:0] qa, qb;
    logic       tca, tcb;

    u74hc161 #(.ic(4'h5), .delay(D)) dut_a (
        .clk(clk), .rst(rst), .vcc(vcc), .gnd(gnd), .mr_n(mr_n),
        .cp(cp), .pe_n(pe_n), .cep(cep), .cet(cet),
        .p0(p[0]), .p1(p[1]), .p2(p[2]), .p3(p[3]),
        .q0(qa[0]), .q1(qa[1]), .q2(qa[2]), .q3(qa[3]), .tc(tca)
    );

    u74hc161 #(.ic(4'h3), .delay(D)) dut_b (
        .clk(clk), .rst(rst), .vcc(vcc), .gnd(gnd), .mr_n(mr_n),
        .cp(cp), .pe_n(pe_n), .cep(cep), .cet(cet),
        .p0(p[0]), .p1(p[1]), .p2(p[2]), .p3(p[3]),
        .q0(qb[0]), .q1(qb[1]), .q2(qb[2]), .q3(qb[3]), .tc(tcb)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: count kept as an integer, the pin value is
    // looked up from the history of values sampled D-1 ticks earlier.
    int         ics [2];
    int         m_cnt [2];
    bit         m_prev;
    int         last_rst;
    int         n;
    logic [4:0] rv [2];
    logic [4:0] hist [2][NT];
    logic [4:0] ex [2];

    task automatic model_edge();
        bit vr;
        bit rise;
        int k0;
        if (n >= NT) begin
            fails++;
            $display("FAIL budget ticks=%0d limit=%0d", n, NT);
            $fatal(1, "tick budget exceeded");
        end
        vr = rst || !vcc;
        if (vr) begin
            for (int k = 0; k < 2; k++) begin
                rv[k]    = {cet && (ics[k] == 15), 4'(ics[k])};
                m_cnt[k] = ics[k];
            end
            m_prev   = 1'b1;
            last_rst = n;
        end else begin
            rise = cp && !m_prev;
            for (int k = 0; k < 2; k++) begin
                hist[k][n] = {cet && (m_cnt[k] == 15), 4'(m_cnt[k])};
                if (!mr_n) m_cnt[k] = 0;
                else if (rise && !pe_n) m_cnt[k] = int'(p);
                else if (rise && cep && cet) m_cnt[k] = (m_cnt[k] + 1) % 16;
            end
            m_prev = cp;
        end
        k0 = n - D + 1;
        for (int k = 0; k < 2; k++)
            ex[k] = (k0 > last_rst) ? hist[k][k0] : rv[k];
        n++;
    endtask

    task automatic chk(input string tag, input logic [4:0] obs,
                       input logic [4:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s tick=%0d got=%h want=%h", tag, n, obs, exp);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("model_a", {tca, qa}, ex[0]);
        chk("model_b", {tcb, qb}, ex[1]);
    endtask

    task automatic pulse();
        cp = 1'b1;
        tick();
        cp = 1'b0;
        tick();
    endtask

    task automatic settle();
        repeat (D + 2) tick();
    endtask

    initial begin
        ics[0] = 5;
        ics[1] = 3;
        n = 0;
        last_rst = 0;
        m_prev = 1'b1;
        rst = 1'b1; vcc = 1'b1; gnd = 1'b0; mr_n = 1'b1;
        cp = 1'b0; pe_n = 1'b1; cep = 1'b0; cet = 1'b0; p = 4'h0;

        tick();
        tick();
        chk("rst_a", {1'b0, qa}, 5'h05);
        chk("rst_b", {1'b0, qb}, 5'h03);
        rst = 1'b0;
        repeat (D) begin
            tick();
            chk("idle_a", {1'b0, qa}, 5'h05);
        end

        mr_n = 1'b0;
        tick();
        mr_n = 1'b1;
        cep = 1'b1;
        cet = 1'b1;
        repeat (16) pulse();
        settle();
        chk("wrap_a", {tca, qa}, 5'h00);

        pe_n = 1'b0; p = 4'hA; cep = 1'b0;
        pulse();
        pe_n = 1'b1; cep = 1'b1;
        settle();
        chk("load_a", {tca, qa}, 5'h0A);
        chk("load_b", {tcb, qb}, 5'h0A);
        repeat (5) pulse();
        settle();
        chk("tc_at_f", {tca, qa}, 5'h1F);
        pulse();
        settle();

        mr_n = 1'b0;
        tick();
        mr_n = 1'b1;
        repeat (7) pulse();
        settle();
        chk("seven", {1'b0, qa}, 5'h07);
        mr_n = 1'b0;
        settle();
        chk("clr", {tca, qa}, 5'h00);
        pe_n = 1'b0; p = 4'hA;
        pulse();
        settle();
        chk("clr_load", {tca, qa}, 5'h00);
        mr_n = 1'b1; pe_n = 1'b1;

        cp = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        cp = 1'b0;
        tick();
        cp = 1'b1;
        tick();
        settle();
        chk("cp_hi_a", {1'b0, qa}, 5'h06);
        chk("cp_hi_b", {1'b0, qb}, 5'h04);
        cp = 1'b0;
        tick();

        mr_n = 1'b0;
        tick();
        mr_n = 1'b1;
        repeat (9) pulse();
        cp = 1'b1;
        tick();
        vcc = 1'b0; cp = 1'b0;
        tick();
        chk("vcc_a", {1'b0, qa}, 5'h05);
        chk("vcc_b", {1'b0, qb}, 5'h03);
        vcc = 1'b1;
        repeat (D + 3) begin
            tick();
            chk("vcc_hold", {1'b0, qb}, 5'h03);
        end

        repeat (1500) begin
            cp   = 1'($urandom_range(0, 1));
            cep  = ($urandom_range(0, 3) != 0);
            cet  = ($urandom_range(0, 3) != 0);
            pe_n = ($urandom_range(0, 7) != 0);
            p    = 4'($urandom);
            mr_n = ($urandom_range(0, 31) != 0);
            rst  = ($urandom_range(0, 99) == 0);
            vcc  = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
